poly_tone_generator: RTL
========================

# poly_tone_generator

Multi-channel square-wave tone synthesiser for the audio path, driven by the CPU's memory-mapped audio registers. Each of NUM_CH channels has a programmable period, multi-level volume and enable. Channel levels are summed into a PCM mix, and that mix is rendered as a single-bit PWM output for the board's audio pin. An optional per-channel volume ramp removes clicks on enable, disable and volume changes.

## Interface
- NUM_CH, 4, number of tone channels (1–8)
- PERIOD_W, 24, width of the period field in clk cycles
- VOL_W, 3, per-channel volume width; level range 0..2^VOL_W-1
- FADE_DIV, 256, clk cycles per ramp step (fade build only; power of two)
- MIX_W (derived, not overridable) = VOL_W + clog2(NUM_CH)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- output_enable  in  1  global enable; low forces silence and holds all channels idle
- cfg_we  in  1  one-cycle write strobe for a channel configuration
- cfg_ch  in  clog2(NUM_CH)  target channel; a value ≥ NUM_CH makes the write a no-op
- cfg_period  in  PERIOD_W  full tone period in cycles; values below 2 select silence
- cfg_vol  in  VOL_W  target volume
- cfg_en  in  1  channel enable
- mix_out  out  MIX_W  registered sum of channel levels
- ch_active  out  NUM_CH  bit i is high while channel i can produce non-zero output
- square_wave_out  out  1  PWM rendering of mix_out

## Operation
- Per-channel state:
  - period, target volume vol_tgt and en, all written by cfg_we
  - half-period counter cnt (PERIOD_W-1 bits)
  - phase bit
  - effective volume vol_eff
- Half period is half = period>>1.
- Tone counter:
  - When half == 0, the channel is silent: cnt = 0 and phase = 0.
  - Otherwise cnt counts 0..half-1. At half-1 it wraps to 0 and phase toggles.
  - Full tone period = 2*half cycles; an odd period rounds down.
- Channel retrigger: a write to a channel clears its cnt and phase on the same edge.
- Write vs. wrap: a write on the same cycle as a wrap or toggle takes precedence; no toggle occurs.
- Channel level = phase ? vol_eff : 0.
- mix_out = sum of all channel levels, zero-extended to MIX_W, so the sum cannot overflow.
- PWM: a free-running MIX_W-bit counter pwm_cnt wraps at 2^MIX_W-1. square_wave_out = (pwm_cnt < mix_out), registered.
- Volume handling without the fade build: vol_eff = en ? vol_tgt : 0, updated on the write edge.
- ch_active[i] = en_i && half_i != 0 && vol_eff_i != 0. In the fade build, a nonzero vol_eff also holds ch_active[i] high (see Configuration).
- Counter idle rule: when a channel's en is low and its vol_eff is 0, its cnt and phase are held at 0.
- When output_enable is low:
  - All cnt, phase and pwm_cnt are held at 0; mix_out and square_wave_out are 0.
  - Configuration writes are still accepted.
  - The fade build also jumps vol_eff directly to its target.

## Timing
- Reset (asynchronous): all configuration and state registers, mix_out, ch_active and square_wave_out go to 0.
- Latency:
  - Write at edge N → new configuration visible at N.
  - The resulting phase or level change appears on mix_out at N+1 and on square_wave_out at N+2.
- The first phase toggle after a write occurs half cycles after the write edge.
- Reset asserted mid-tone or mid-ramp clears everything immediately. There is no resume.
- Back-to-back writes are allowed every cycle; the last write to a channel wins.

## Configuration
- Macro: POLY_TONE_GEN_FADE_EN.
- When the macro is defined:
  - Every FADE_DIV cycles, a shared strobe fires.
  - On each strobe, each channel moves vol_eff one step toward its target, where target = en ? vol_tgt : 0.
  - When a channel is disabled, it keeps toggling until vol_eff reaches 0. Only then does the counter idle rule apply.
  - ch_active stays high while vol_eff != 0.
- When the macro is not defined:
  - No ramp logic is built.
  - vol_eff follows its target on the write edge.
  - Disabling a channel silences it on that edge.

## Test plan
- Single channel, period=10, vol=7, en=1, output_enable=1: mix_out alternates 0/7 every 5 cycles, first rise 6 cycles after the write edge, and the square_wave_out duty cycle is 7/(2^MIX_W) during the high phase.
- Two channels with period 8 and period 12 at vol 7: mix_out takes values only in {0, 7, 14}, and the pattern repeats every 24 cycles.
- Retrigger: rewrite period=10 mid-phase on the same cycle as a scheduled toggle: no toggle occurs, phase=0, and the next toggle comes 5 cycles later.
- Boundaries:
  - period=1 → channel silent and ch_active low.
  - cfg_ch=NUM_CH → no state change.
  - output_enable low for 3 cycles → mix_out=0, and the tone restarts from phase 0.
- Fade build with FADE_DIV=4: enable at vol=7 → vol_eff steps 1..7 over 28 cycles. Disable → the tone keeps toggling, and ch_active falls after 7 steps.
- Assert rst mid-ramp: all outputs are 0 immediately. After deassertion, a write with vol=3 and no fade build produces a mix amplitude of 3 on the next toggle.

Source files
------------

// File: rtl/poly_tone_generator.sv
// Multi-channel square-wave tone synthesiser: per-channel period/volume/enable, PCM mix and PWM output.
// Optional volume ramp is built when POLY_TONE_GEN_FADE_EN is defined.
module poly_tone_generator #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 24,
  parameter int VOL_W    = 3,
  parameter int FADE_DIV = 256,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIX_W   = VOL_W + $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                output_enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [VOL_W-1:0]    cfg_vol,
  input  logic                cfg_en,
  output logic [MIX_W-1:0]    mix_out,
  output logic [NUM_CH-1:0]   ch_active,
  output logic                square_wave_out
);

  localparam int HALF_W = PERIOD_W - 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("poly_tone_generator: NUM_CH must be in 1..8");
  end
  if (FADE_DIV < 1 || (FADE_DIV & (FADE_DIV - 1)) != 0) begin : g_bad_fade_div
    $error("poly_tone_generator: FADE_DIV must be a power of two");
  end

  // Only half = period>>1 is ever used, so the period LSB is dropped at the port.
  logic unused_period_lsb;
  assign unused_period_lsb = cfg_period[0];

  logic [VOL_W-1:0] level [NUM_CH];
  logic [MIX_W-1:0] mix_sum;
  logic [MIX_W-1:0] pwm_cnt_reg;

`ifdef POLY_TONE_GEN_FADE_EN
  localparam int FADE_CW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  logic [FADE_CW-1:0] fade_cnt_reg;
  logic               fade_strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fade_cnt_reg <= '0;
    end else begin
      fade_cnt_reg <= fade_cnt_reg + FADE_CW'(1);
    end
  end
  assign fade_strobe = (FADE_DIV == 1) || (fade_cnt_reg == FADE_CW'(FADE_DIV - 1));
`endif

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [HALF_W-1:0] half_reg;
    logic [HALF_W-1:0] cnt_reg;
    logic [VOL_W-1:0]  vol_tgt_reg;
    logic [VOL_W-1:0]  vol_eff_reg;
    logic              en_reg;
    logic              phase_reg;
    logic              hit;
    logic              idle;
    logic [VOL_W-1:0]  vol_goal;

    assign hit      = cfg_we && (cfg_ch == CH_W'(gi));
    assign vol_goal = en_reg ? vol_tgt_reg : '0;
    assign idle     = !en_reg && (vol_eff_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        half_reg    <= '0;
        cnt_reg     <= '0;
        vol_tgt_reg <= '0;
        vol_eff_reg <= '0;
        en_reg      <= 1'b0;
        phase_reg   <= 1'b0;
      end else begin
        // A write retriggers the channel and overrides any wrap on the same edge.
        if (hit) begin
          half_reg    <= cfg_period[PERIOD_W-1:1];
          vol_tgt_reg <= cfg_vol;
          en_reg      <= cfg_en;
          cnt_reg     <= '0;
          phase_reg   <= 1'b0;
        end else if (!output_enable || half_reg == '0 || idle) begin
          cnt_reg   <= '0;
          phase_reg <= 1'b0;
        end else if (cnt_reg == half_reg - HALF_W'(1)) begin
          cnt_reg   <= '0;
          phase_reg <= ~phase_reg;
        end else begin
          cnt_reg <= cnt_reg + HALF_W'(1);
        end

`ifdef POLY_TONE_GEN_FADE_EN
        if (!output_enable) begin
          vol_eff_reg <= vol_goal;
        end else if (fade_strobe) begin
          if (vol_eff_reg < vol_goal) begin
            vol_eff_reg <= vol_eff_reg + VOL_W'(1);
          end else if (vol_eff_reg > vol_goal) begin
            vol_eff_reg <= vol_eff_reg - VOL_W'(1);
          end
        end
`else
        if (hit) begin
          vol_eff_reg <= cfg_en ? cfg_vol : '0;
        end
`endif
      end
    end

    assign level[gi] = phase_reg ? vol_eff_reg : '0;

`ifdef POLY_TONE_GEN_FADE_EN
    // A fading-out channel stays active until its ramp has reached zero.
    assign ch_active[gi] = (en_reg && half_reg != '0 && vol_eff_reg != '0) || (vol_eff_reg != '0);
`else
    assign ch_active[gi] = en_reg && (half_reg != '0) && (vol_eff_reg != '0);
`endif
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_sum = mix_sum + MIX_W'(level[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_out         <= '0;
      pwm_cnt_reg     <= '0;
      square_wave_out <= 1'b0;
    end else if (!output_enable) begin
      mix_out         <= '0;
      pwm_cnt_reg     <= '0;
      square_wave_out <= 1'b0;
    end else begin
      mix_out         <= mix_sum;
      pwm_cnt_reg     <= pwm_cnt_reg + MIX_W'(1);
      square_wave_out <= (pwm_cnt_reg < mix_out);
    end
  end

endmodule
